// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state codes, opcodes and mux encodings for the multicycle controller
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select; 2'b11 is never driven
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Instruction class dispatch out of DECODE; unknown opcodes trap
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_RTYPE:     decode_next = S_EXEC;
      OP_BEQ:       decode_next = S_BRANCH;
      OP_J:         decode_next = S_JUMP;
      OP_ADDI:      decode_next = S_ADDIEX;
      default:      decode_next = S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// rtl/mc_out_decode.sv - Moore output decode for the multicycle controller
module mc_out_decode
  import mc_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  input  logic       i_rst_n,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_source,
  output logic       o_illegal_op
);

  logic w_mem_read, w_mem_write, w_ir_write, w_pc_write, w_pc_write_cond;
  logic w_reg_write, w_illegal_op;

  // Per-state control values; anything not set for a state stays 0
  always_comb begin
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    o_iord          = 1'b0;
    w_ir_write      = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_reg_write     = 1'b0;
    o_reg_dst       = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = SRCB_REG;
    o_alu_op        = ALUOP_ADD;
    o_pc_source     = PCSRC_ALU;
    w_illegal_op    = 1'b0;
    case (i_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        w_ir_write  = i_mem_ready;
        w_pc_write  = i_mem_ready;
      end
      S_DECODE: o_alu_src_b = SRCB_IMM_SL2;
      S_MEMADR, S_ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        o_iord      = 1'b1;
      end
      S_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = ALUOP_SUB;
        w_pc_write_cond = 1'b1;
        o_pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        o_pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_TRAP:   w_illegal_op = 1'b1;
      default: ;
    endcase
  end

  // Enables are forced low while reset is held so nothing commits mid-reset
  assign o_mem_read      = w_mem_read      & i_rst_n;
  assign o_mem_write     = w_mem_write     & i_rst_n;
  assign o_ir_write      = w_ir_write      & i_rst_n;
  assign o_pc_write      = w_pc_write      & i_rst_n;
  assign o_pc_write_cond = w_pc_write_cond & i_rst_n;
  assign o_reg_write     = w_reg_write     & i_rst_n;
  assign o_illegal_op    = w_illegal_op    & i_rst_n;

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-style control FSM top
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_next_state;

  // State register; reset abandons any in-flight access and restarts at FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // Next-state sequencing; memory states wait on mem_ready
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next_state = decode_next(op);
      S_MEMADR: w_next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next_state = S_ALUWB;
      S_ADDIEX: w_next_state = S_ADDIWB;
      default:  w_next_state = S_FETCH;
    endcase
  end

  assign state = r_state;

  mc_out_decode u_out_decode (
    .i_state         (r_state),
    .i_mem_ready     (mem_ready),
    .i_rst_n         (rst_n),
    .o_mem_read      (mem_read),
    .o_mem_write     (mem_write),
    .o_iord          (iord),
    .o_ir_write      (ir_write),
    .o_pc_write      (pc_write),
    .o_pc_write_cond (pc_write_cond),
    .o_reg_write     (reg_write),
    .o_reg_dst       (reg_dst),
    .o_mem_to_reg    (mem_to_reg),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_alu_op        (alu_op),
    .o_pc_source     (pc_source),
    .o_illegal_op    (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam int FE = 0, DE = 1, MA = 2, MR = 3, MB = 4, MW = 5, EX = 6, AW = 7;
  localparam int BR = 8, JP = 9, AX = 10, AB = 11, TR = 12;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int passed = 0;
  int total  = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  logic [16:0] ctrl;
  assign ctrl = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                 reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                 pc_source, illegal_op};

  // Control table: field-by-field meaning of each state
  function automatic logic [16:0] exp_ctrl(input int s, input logic mr);
    logic rd, wr, io, irw, pcw, pcc, rw, rdst, m2r, sa, ill;
    logic [1:0] sb, ao, ps;
    {rd, wr, io, irw, pcw, pcc, rw, rdst, m2r, sa, ill} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (s)
      FE: begin rd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      DE: sb = 2'b11;
      MA: begin sa = 1; sb = 2'b10; end
      MR: begin rd = 1; io = 1; end
      MB: begin rw = 1; m2r = 1; end
      MW: begin wr = 1; io = 1; end
      EX: begin sa = 1; ao = 2'b10; end
      AW: begin rw = 1; rdst = 1; end
      BR: begin sa = 1; ao = 2'b01; pcc = 1; ps = 2'b01; end
      JP: begin pcw = 1; ps = 2'b10; end
      AX: begin sa = 1; sb = 2'b10; end
      AB: rw = 1;
      TR: ill = 1;
      default: ;
    endcase
    return {rd, wr, io, irw, pcw, pcc, rw, rdst, m2r, sa, sb, ao, ps, ill};
  endfunction

  // FETCH values with every enable forced low
  function automatic logic [16:0] exp_reset_ctrl();
    return {10'b0, 2'b01, 2'b00, 2'b00, 1'b0};
  endfunction

  task automatic check_now(input int es, input logic [16:0] ec, input string tag);
    logic [3:0] es4;
    es4 = es[3:0];
    total++;
    if (state !== es4) $display("FAIL %s state: got %0d expected %0d", tag, state, es4);
    else passed++;
    total++;
    if (ctrl !== ec) $display("FAIL %s ctrl(state %0d): got %b expected %b", tag, es, ctrl, ec);
    else passed++;
    total++;
    if ((mem_read & mem_write) || (pc_write & pc_write_cond) || (pc_source === 2'b11))
      $display("FAIL %s exclusivity: rd=%b wr=%b pcw=%b pcc=%b pcs=%b expected no conflict",
               tag, mem_read, mem_write, pc_write, pc_write_cond, pc_source);
    else passed++;
  endtask

  task automatic step(input logic mr, input int es, input string tag);
    @(negedge clk);
    mem_ready = mr;
    #1;
    check_now(es, exp_ctrl(es, mr), tag);
  endtask

  // Reference trace of one instruction from its opcode and injected wait counts
  task automatic run_instr(input logic [5:0] o, input int wf, input int wm, input string tag);
    op = o;
    for (int i = 0; i < wf; i++) step(1'b0, FE, tag);
    step(1'b1, FE, tag);
    step(1'($urandom), DE, tag);
    case (o)
      LW: begin
        step(1'($urandom), MA, tag);
        for (int i = 0; i < wm; i++) step(1'b0, MR, tag);
        step(1'b1, MR, tag);
        step(1'($urandom), MB, tag);
      end
      SW: begin
        step(1'($urandom), MA, tag);
        for (int i = 0; i < wm; i++) step(1'b0, MW, tag);
        step(1'b1, MW, tag);
      end
      RT:   begin step(1'($urandom), EX, tag); step(1'($urandom), AW, tag); end
      BEQ:  step(1'($urandom), BR, tag);
      JMP:  step(1'($urandom), JP, tag);
      ADDI: begin step(1'($urandom), AX, tag); step(1'($urandom), AB, tag); end
      default: step(1'($urandom), TR, tag);
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op = RT;
    repeat (2) @(negedge clk);
    #1;
    check_now(FE, exp_reset_ctrl(), "reset_hold");
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check_now(FE, exp_ctrl(FE, 1'b0), "reset_release");
  endtask

  task automatic test_lw();
    run_instr(LW, 0, 0, "lw");
    run_instr(LW, 2, 1, "lw_wait");
  endtask

  task automatic test_sw_wait();
    run_instr(SW, 0, 3, "sw_wait3");
    run_instr(SW, 0, 0, "sw");
  endtask

  task automatic test_jump_branch_rtype();
    run_instr(JMP, 0, 0, "j");
    run_instr(BEQ, 0, 0, "beq");
    run_instr(RT, 1, 0, "rtype");
    run_instr(ADDI, 0, 0, "addi");
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 0, 0, "illegal");
    run_instr(6'b000001, 0, 0, "illegal2");
  endtask

  task automatic test_reset_mid_access();
    op = SW;
    step(1'b1, FE, "rst_mid");
    step(1'b0, DE, "rst_mid");
    step(1'b0, MA, "rst_mid");
    step(1'b0, MW, "rst_mid");
    step(1'b0, MW, "rst_mid");
    #2;
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_now(FE, exp_reset_ctrl(), "rst_mid_assert");
    @(negedge clk);
    #1;
    check_now(FE, exp_reset_ctrl(), "rst_mid_held");
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check_now(FE, exp_ctrl(FE, 1'b0), "rst_mid_release");
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    logic [5:0] o;
    ops = '{LW, SW, RT, BEQ, JMP, ADDI, 6'b000000};
    for (int n = 0; n < 80; n++) begin
      int k;
      k = int'($urandom_range(0, 6));
      o = (k == 6) ? 6'($urandom) : ops[k];
      run_instr(o, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_jump_branch_rtype();
    test_illegal();
    test_reset_mid_access();
    test_random();
    step(1'b0, FE, "final");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
